// File: rtl/uart_fifo_bridge.sv
// CPU-side byte FIFOs bridged to a CPLD UART over a shared, arbitrated data bus.
// The FSM moves RX bytes in and TX bytes out using low-active read/write strobes.
module uart_fifo_bridge #(
  parameter int FIFO_DEPTH    = 16,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_i,
  input  logic       we_i,
  input  logic       addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_o,
  output logic       uart_rdn,
  output logic       uart_wrn,
  input  logic       uart_dataready,
  input  logic       uart_tbre,
  input  logic       uart_tsre,
  output logic       bus_req_o,
  input  logic       bus_gnt_i,
  output logic       bus_oe_o,
  output logic [7:0] bus_data_o,
  input  logic [7:0] bus_data_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [3:0]    STB_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_STB   = 3'd1,
    RD_REL   = 3'd2,
    WR_SETUP = 3'd3,
    WR_STB   = 3'd4,
    WR_HOLD  = 3'd5,
    WR_WAIT  = 3'd6
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [3:0]    cnt_r;
  logic          dr_meta_r, tbre_meta_r, tsre_meta_r;
  logic          dr_s, tbre_s, tsre_s;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r, tx_wr_ptr_r, tx_rd_ptr_r;
  logic [CW-1:0] rx_cnt_r, tx_cnt_r, rx_cnt_nxt_s, tx_cnt_nxt_s;
  logic          rx_ovf_r, tx_ovf_r, rx_ovf_nxt_s, tx_ovf_nxt_s;
  logic [7:0]    data_r, bdata_r;
  logic          irq_r, rdn_r, wrn_r, req_r, oe_r;

  logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic rx_go_s, tx_go_s, rx_go_nxt_s, tx_go_nxt_s;
  logic cpu_rd_s, cpu_tx_wr_s, status_rd_s, stb_last_s, wr_drive_nxt_s;
  logic rx_push_s, rx_push_ok_s, rx_pop_s, tx_push_ok_s, tx_pop_s;
  logic [7:0] status_s;

  assign rx_empty_s  = (rx_cnt_r == ZERO_CNT);
  assign rx_full_s   = (rx_cnt_r == FULL_CNT);
  assign tx_empty_s  = (tx_cnt_r == ZERO_CNT);
  assign tx_full_s   = (tx_cnt_r == FULL_CNT);
  assign rx_go_s     = dr_s && !rx_full_s;
  assign tx_go_s     = !tx_empty_s && tbre_s && tsre_s;
  assign stb_last_s  = (cnt_r == STB_LAST);

  assign cpu_rd_s    = ce_i && !we_i;
  assign cpu_tx_wr_s = ce_i && we_i && !addr_i;
  assign status_rd_s = cpu_rd_s && addr_i;

  // A full FIFO still takes a push when the other side pops it in the same cycle.
  assign rx_push_s    = (state_r == RD_STB) && stb_last_s;
  assign rx_pop_s     = cpu_rd_s && !addr_i && !rx_empty_s;
  assign rx_push_ok_s = rx_push_s && (!rx_full_s || rx_pop_s);
  assign tx_pop_s     = (state_r == WR_HOLD) && !tx_empty_s;
  assign tx_push_ok_s = cpu_tx_wr_s && (!tx_full_s || tx_pop_s);

  assign rx_cnt_nxt_s = rx_cnt_r + CW'(rx_push_ok_s) - CW'(rx_pop_s);
  assign tx_cnt_nxt_s = tx_cnt_r + CW'(tx_push_ok_s) - CW'(tx_pop_s);
  assign rx_ovf_nxt_s = (rx_ovf_r && !status_rd_s) || (dr_s && rx_full_s);
  assign tx_ovf_nxt_s = (tx_ovf_r && !status_rd_s) || (cpu_tx_wr_s && !tx_push_ok_s);
  assign status_s     = {rx_ovf_r, tx_ovf_r, 2'b00, tx_full_s, tx_empty_s, rx_full_s, !rx_empty_s};

  // Next-cycle view of the request terms so bus_req_o can be a flop.
  assign rx_go_nxt_s    = dr_meta_r && (rx_cnt_nxt_s != FULL_CNT);
  assign tx_go_nxt_s    = (tx_cnt_nxt_s != ZERO_CNT) && tbre_meta_r && tsre_meta_r;
  assign wr_drive_nxt_s = (state_nxt_s == WR_SETUP) || (state_nxt_s == WR_STB) ||
                          (state_nxt_s == WR_HOLD);

  // Two-flop synchronizers for the CPLD status lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      {dr_meta_r, tbre_meta_r, tsre_meta_r} <= 3'b000;
      {dr_s, tbre_s, tsre_s}                <= 3'b000;
    end else begin
      {dr_meta_r, tbre_meta_r, tsre_meta_r} <= {uart_dataready, uart_tbre, uart_tsre};
      {dr_s, tbre_s, tsre_s}                <= {dr_meta_r, tbre_meta_r, tsre_meta_r};
    end
  end

  // Next-state logic; RX has priority over TX when the grant arrives.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus_gnt_i && rx_go_s)      state_nxt_s = RD_STB;
        else if (bus_gnt_i && tx_go_s) state_nxt_s = WR_SETUP;
        else                           state_nxt_s = IDLE;
      end
      RD_STB:   state_nxt_s = stb_last_s ? RD_REL : RD_STB;
      RD_REL:   state_nxt_s = IDLE;
      WR_SETUP: state_nxt_s = WR_STB;
      WR_STB:   state_nxt_s = stb_last_s ? WR_HOLD : WR_STB;
      WR_HOLD:  state_nxt_s = WR_WAIT;
      WR_WAIT:  state_nxt_s = ((cnt_r >= 4'd2) && tsre_s) ? IDLE : WR_WAIT;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // State register and per-state cycle counter (saturating for long waits).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) cnt_r <= 4'd0;
      else if (cnt_r != 4'hF)     cnt_r <= cnt_r + 4'd1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      rx_cnt_r    <= ZERO_CNT;
      tx_cnt_r    <= ZERO_CNT;
      rx_ovf_r    <= 1'b0;
      tx_ovf_r    <= 1'b0;
    end else begin
      if (rx_push_ok_s) rx_wr_ptr_r <= rx_wr_ptr_r + AW'(1);
      if (rx_pop_s)     rx_rd_ptr_r <= rx_rd_ptr_r + AW'(1);
      if (tx_push_ok_s) tx_wr_ptr_r <= tx_wr_ptr_r + AW'(1);
      if (tx_pop_s)     tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1);
      rx_cnt_r <= rx_cnt_nxt_s;
      tx_cnt_r <= tx_cnt_nxt_s;
      rx_ovf_r <= rx_ovf_nxt_s;
      tx_ovf_r <= tx_ovf_nxt_s;
    end
  end

  // FIFO storage; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && rx_push_ok_s) rx_mem[rx_wr_ptr_r] <= bus_data_i;
    if (!rst && tx_push_ok_s) tx_mem[tx_wr_ptr_r] <= data_i;
  end

  // Registered CPU and CPLD-side outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= 8'h00;
      irq_r   <= 1'b0;
      rdn_r   <= 1'b1;
      wrn_r   <= 1'b1;
      req_r   <= 1'b0;
      oe_r    <= 1'b0;
      bdata_r <= 8'h00;
    end else begin
      if (cpu_rd_s) data_r <= addr_i ? status_s : (rx_empty_s ? 8'h00 : rx_mem[rx_rd_ptr_r]);
      irq_r   <= (rx_cnt_nxt_s != ZERO_CNT) || rx_ovf_nxt_s || tx_ovf_nxt_s;
      rdn_r   <= (state_nxt_s != RD_STB);
      wrn_r   <= (state_nxt_s != WR_STB);
      req_r   <= (state_nxt_s != IDLE) || rx_go_nxt_s || tx_go_nxt_s;
      oe_r    <= wr_drive_nxt_s;
      bdata_r <= wr_drive_nxt_s ? tx_mem[tx_rd_ptr_r] : 8'h00;
    end
  end

  assign data_o     = data_r;
  assign irq_o      = irq_r;
  assign uart_rdn   = rdn_r;
  assign uart_wrn   = wrn_r;
  assign bus_req_o  = req_r;
  assign bus_oe_o   = oe_r;
  assign bus_data_o = bdata_r;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge (FIFO_DEPTH=16, STROBE_CYCLES=2).
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce_i = 1'b0, we_i = 1'b0, addr_i = 1'b0;
  logic [7:0] data_i = 8'h00, bus_data_i = 8'h00;
  logic       uart_dataready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0, bus_gnt_i = 1'b0;
  logic [7:0] data_o, bus_data_o;
  logic       irq_o, uart_rdn, uart_wrn, bus_req_o, bus_oe_o;

  int checks = 0;
  int errors = 0;

  uart_fifo_bridge dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .irq_o(irq_o), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_oe_o(bus_oe_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i)
  );

  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    tick;
    ce_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    tick;
    d = data_o;
    ce_i = 1'b0;
  endtask

  task automatic status_is(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(1'b1, d);
    chk(tag, d, exp);
  endtask

  task automatic data_is(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(1'b0, d);
    chk(tag, d, exp);
  endtask

  // Presents one byte from the CPLD and waits for the read strobe.
  task automatic rx_byte(input logic [7:0] v, input int extra);
    logic got = 1'b0;
    bus_data_i = v;
    uart_dataready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (!uart_rdn) got = 1'b1;
    end
    uart_dataready = 1'b0;
    chk("rx_strobe_seen", got, 1'b1);
    repeat (extra) tick;
  endtask

  initial begin
    logic       seen, wseen, prev_wrn;
    int         low_cnt, first, ntx;
    logic [7:0] wbyte;

    // Reset state
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_rdn", uart_rdn, 1'b1);
    chk("rst_wrn", uart_wrn, 1'b1);
    chk("rst_req", bus_req_o, 1'b0);
    chk("rst_oe", bus_oe_o, 1'b0);
    chk("rst_data_o", data_o, 8'h00);
    chk("rst_irq", irq_o, 1'b0);
    status_is("rst_status", 8'h04);
    data_is("empty_rx_read", 8'h00);

    // RX path
    bus_gnt_i = 1'b1;
    bus_data_i = 8'h5A;
    uart_dataready = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (!uart_rdn) begin
        low_cnt++;
        uart_dataready = 1'b0;
      end
    end
    chk("rx_rdn_low_cycles", low_cnt, 2);
    chk("rx_irq_set", irq_o, 1'b1);
    status_is("rx_status", 8'h05);
    data_is("rx_data", 8'h5A);
    chk("rx_irq_clear", irq_o, 1'b0);

    // TX path with cycle-exact strobe sequence
    uart_tbre = 1'b1;
    uart_tsre = 1'b1;
    repeat (3) tick;
    cpu_write(1'b0, 8'h41);
    chk("tx_c0_oe", bus_oe_o, 1'b0);
    tick;
    chk("tx_setup_oe", bus_oe_o, 1'b1);
    chk("tx_setup_wrn", uart_wrn, 1'b1);
    chk("tx_setup_data", bus_data_o, 8'h41);
    tick;
    chk("tx_stb1_wrn", uart_wrn, 1'b0);
    tick;
    chk("tx_stb2_wrn", uart_wrn, 1'b0);
    tick;
    chk("tx_hold_wrn", uart_wrn, 1'b1);
    chk("tx_hold_oe", bus_oe_o, 1'b1);
    chk("tx_hold_data", bus_data_o, 8'h41);
    tick;
    chk("tx_wait_oe", bus_oe_o, 1'b0);
    chk("tx_wait_data", bus_data_o, 8'h00);
    status_is("tx_empty_after", 8'h04);

    // TX overflow: 17 writes while the shift register is busy
    uart_tsre = 1'b0;
    repeat (6) tick;
    for (int i = 0; i < 17; i++) cpu_write(1'b0, 8'(8'h10 + i));
    chk("txovf_irq", irq_o, 1'b1);
    chk("txovf_no_req", bus_req_o, 1'b0);
    status_is("txovf_status1", 8'h48);
    chk("txovf_irq_clear", irq_o, 1'b0);
    status_is("txovf_status2", 8'h08);
    cpu_write(1'b1, 8'hFF);
    status_is("addr1_write_ignored", 8'h08);

    // Drain TX and verify byte order; the 17th byte must not appear
    uart_tsre = 1'b1;
    ntx = 0;
    prev_wrn = 1'b1;
    for (int i = 0; i < 400 && ntx < 16; i++) begin
      tick;
      if (!uart_wrn && prev_wrn) begin
        chk("tx_drain_byte", bus_data_o, 8'(8'h10 + ntx));
        ntx++;
      end
      prev_wrn = uart_wrn;
    end
    chk("tx_drain_count", ntx, 16);
    repeat (5) tick;
    status_is("tx_drained_status", 8'h04);

    // Priority and grant gating
    bus_gnt_i = 1'b0;
    repeat (5) tick;
    cpu_write(1'b0, 8'h77);
    bus_data_i = 8'hC3;
    uart_dataready = 1'b1;
    repeat (4) tick;
    chk("prio_req", bus_req_o, 1'b1);
    chk("prio_no_rdn", uart_rdn, 1'b1);
    chk("prio_no_wrn", uart_wrn, 1'b1);
    bus_gnt_i = 1'b1;
    first = 0;
    wseen = 1'b0;
    wbyte = 8'h00;
    for (int i = 0; i < 60 && !wseen; i++) begin
      tick;
      if (!uart_rdn && first == 0) first = 1;
      if (!uart_rdn) uart_dataready = 1'b0;
      if (!uart_wrn && first == 0) first = 2;
      if (!uart_wrn) begin
        wseen = 1'b1;
        wbyte = bus_data_o;
      end
    end
    chk("prio_read_first", first, 1);
    chk("prio_write_seen", wseen, 1'b1);
    chk("prio_write_byte", wbyte, 8'h77);
    repeat (8) tick;
    data_is("prio_rx_byte", 8'hC3);

    // Fill RX; 16th byte lands while the CPU pops the head
    for (int i = 0; i < 15; i++) rx_byte(8'(8'hA0 + i), 4);
    bus_data_i = 8'hAF;
    uart_dataready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      if (!uart_rdn) seen = 1'b1;
    end
    uart_dataready = 1'b0;
    chk("rx16_strobe_seen", seen, 1'b1);
    tick;
    data_is("rx_pop_during_push", 8'hA0);
    repeat (3) tick;
    rx_byte(8'hB0, 4);
    status_is("rx_full_status", 8'h07);

    // Dataready with RX full: no read, rx_ovf set
    bus_data_i = 8'hEE;
    uart_dataready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (!uart_rdn) seen = 1'b1;
    end
    chk("rxfull_no_read", seen, 1'b0);
    chk("rxfull_no_req", bus_req_o, 1'b0);
    uart_dataready = 1'b0;
    repeat (3) tick;
    status_is("rxovf_status1", 8'h87);
    status_is("rxovf_status2", 8'h07);
    for (int i = 0; i < 15; i++) data_is("rx_order", 8'(8'hA1 + i));
    data_is("rx_order_last", 8'hB0);
    status_is("rx_drained_status", 8'h04);
    chk("rx_drained_irq", irq_o, 1'b0);

    // Reset in the middle of the write strobe
    cpu_write(1'b0, 8'h55);
    tick;
    tick;
    chk("mid_wr_stb_wrn", uart_wrn, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_abort_wrn", uart_wrn, 1'b1);
    chk("rst_abort_oe", bus_oe_o, 1'b0);
    chk("rst_abort_req", bus_req_o, 1'b0);
    chk("rst_abort_data_o", data_o, 8'h00);
    status_is("rst_abort_status", 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
